// File: rtl/gddr_rx_align.sv
// Word-alignment trainer for GDDR receive lanes: pulses each lane's ALIGNWD slip input until
// the training pattern locks or the slip budget is spent, then reports lock/done/error.
module gddr_rx_align #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned DATA_W    = 8,
    parameter logic [7:0]  PATTERN   = 8'h0F,
    parameter int unsigned MATCH_CNT = 8,
    parameter int unsigned SETTLE    = 4
) (
    input  logic                    sclk,
    input  logic                    rst,
    input  logic                    ready,
    input  logic                    retrain,
    input  logic [LANES*DATA_W-1:0] rx_data,
    output logic [LANES-1:0]        alignwd,
    output logic [LANES-1:0]        lane_ok,
    output logic [LANES*4-1:0]      slip_count,
    output logic                    done,
    output logic                    error
);
    localparam int unsigned      CNT_W       = 4;
    localparam logic [DATA_W-1:0] PAT        = PATTERN[DATA_W-1:0];
    localparam logic [CNT_W-1:0]  MATCH_LAST  = CNT_W'(MATCH_CNT - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]  SLIP_MAX    = CNT_W'(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_SETTLE,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    logic             r_ready_m;
    logic             r_ready_s;
    logic             r_done;
    logic             r_error;
    logic             w_clear;
    logic [LANES-1:0] w_term;
    logic [LANES-1:0] w_fail;

    // ready comes from another clock domain
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_ready_m <= 1'b0;
            r_ready_s <= 1'b0;
        end else begin
            r_ready_m <= ready;
            r_ready_s <= r_ready_m;
        end
    end

    // Same condition that pulls every lane out of a terminal state this cycle
    assign w_clear = !r_ready_s || retrain;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_match;
        logic [CNT_W-1:0] w_match_nxt;
        logic [CNT_W-1:0] r_settle;
        logic [CNT_W-1:0] w_settle_nxt;
        logic [CNT_W-1:0] r_slip;
        logic [CNT_W-1:0] w_slip_nxt;
        logic             r_alignwd;
        logic             r_lane_ok;
        logic             w_hit;

        assign w_hit = (rx_data[n*DATA_W +: DATA_W] == PAT);

        // Next-state and counter updates; ready_s low beats retrain
        always_comb begin
            w_state_nxt  = r_state;
            w_match_nxt  = r_match;
            w_settle_nxt = r_settle;
            w_slip_nxt   = r_slip;
            if (!r_ready_s) begin
                w_state_nxt = ST_IDLE;
            end else if (retrain) begin
                w_state_nxt = ST_CHECK;
                w_match_nxt = '0;
                w_slip_nxt  = '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        w_state_nxt = ST_CHECK;
                        w_match_nxt = '0;
                        w_slip_nxt  = '0;
                    end
                    ST_CHECK: begin
                        if (w_hit) begin
                            if (r_match == MATCH_LAST) begin
                                w_state_nxt = ST_LOCKED;
                            end else begin
                                w_match_nxt = r_match + CNT_W'(1);
                            end
                        end else if (r_slip < SLIP_MAX) begin
                            w_state_nxt = ST_SLIP;
                            w_slip_nxt  = r_slip + CNT_W'(1);
                        end else begin
                            w_state_nxt = ST_FAIL;
                        end
                    end
                    ST_SLIP: begin
                        w_state_nxt  = ST_SETTLE;
                        w_settle_nxt = '0;
                    end
                    ST_SETTLE: begin
                        if (r_settle == SETTLE_LAST) begin
                            w_state_nxt = ST_CHECK;
                            w_match_nxt = '0;
                        end else begin
                            w_settle_nxt = r_settle + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge sclk) begin
            if (rst) begin
                r_state   <= ST_IDLE;
                r_match   <= '0;
                r_settle  <= '0;
                r_slip    <= '0;
                r_alignwd <= 1'b0;
                r_lane_ok <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_match   <= w_match_nxt;
                r_settle  <= w_settle_nxt;
                r_slip    <= w_slip_nxt;
                r_alignwd <= (w_state_nxt == ST_SLIP);
                r_lane_ok <= (w_state_nxt == ST_LOCKED);
            end
        end

        assign w_term[n]              = (r_state == ST_LOCKED) || (r_state == ST_FAIL);
        assign w_fail[n]              = (r_state == ST_FAIL);
        assign alignwd[n]             = r_alignwd;
        assign lane_ok[n]             = r_lane_ok;
        assign slip_count[n*4 +: 4]   = r_slip;
    end

    // done/error trail the last terminal lane by one cycle
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done  <= !w_clear && (&w_term);
            r_error <= !w_clear && (&w_term) && (|w_fail);
        end
    end

    assign done  = r_done;
    assign error = r_error;

endmodule

// File: tb/tb_gddr_rx_align.sv
// Bench for gddr_rx_align: lane model rotates each word once per alignwd pulse; expected
// training outcomes are queued and compared by a monitor whenever done rises.
module tb_gddr_rx_align;
    localparam int unsigned LANES     = 2;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MATCH_CNT = 8;
    localparam int unsigned SETTLE    = 4;
    localparam logic [7:0]  PATTERN   = 8'h0F;

    typedef struct {
        logic [1:0] lane_ok;
        logic       error;
        int         slip0;
        int         slip1;
        int         p0;
        int         p1;
    } exp_t;

    logic        sclk = 1'b0;
    logic        rst;
    logic        ready;
    logic        retrain;
    logic [15:0] rx_data;
    logic [1:0]  alignwd;
    logic [1:0]  lane_ok;
    logic [7:0]  slip_count;
    logic        done;
    logic        error;

    logic [7:0] base [2];
    int         rot_base [2];
    int         pulses [2];
    int         last_rise [2];
    bit [1:0]   frozen;
    bit [1:0]   corrupt;
    bit [1:0]   aw_q1;
    bit         done_q1;
    int         cyc;
    int         n_checks;
    int         n_pass;
    exp_t       sb [$];

    gddr_rx_align #(
        .LANES     (LANES),
        .DATA_W    (DATA_W),
        .PATTERN   (PATTERN),
        .MATCH_CNT (MATCH_CNT),
        .SETTLE    (SETTLE)
    ) dut (
        .sclk       (sclk),
        .rst        (rst),
        .ready      (ready),
        .retrain    (retrain),
        .rx_data    (rx_data),
        .alignwd    (alignwd),
        .lane_ok    (lane_ok),
        .slip_count (slip_count),
        .done       (done),
        .error      (error)
    );

    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    function automatic logic [7:0] rotl(input logic [7:0] w, input int k);
        logic [7:0] r;
        r = w;
        for (int i = 0; i < (k % 8); i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Deserializer model: word slides one bit per slip unless frozen
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            logic [7:0] w;
            w = frozen[n] ? base[n] : rotl(base[n], pulses[n] - rot_base[n]);
            if (corrupt[n]) w = ~w;
            rx_data[n*8 +: 8] = w;
        end
    end

    function automatic void check(input string name, input bit ok, input int act, input int want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, want);
    endfunction

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic pulse_retrain();
        retrain = 1'b1;
        step();
        retrain = 1'b0;
    endtask

    task automatic set_lane(input int n, input logic [7:0] b, input bit frz);
        base[n]     = b;
        frozen[n]   = frz;
        rot_base[n] = pulses[n];
    endtask

    task automatic push_exp(input logic [1:0] lo, input logic er, input int s0, input int s1,
                            input int dp0, input int dp1);
        exp_t e;
        e.lane_ok = lo;
        e.error   = er;
        e.slip0   = s0;
        e.slip1   = s1;
        e.p0      = pulses[0] + dp0;
        e.p1      = pulses[1] + dp1;
        sb.push_back(e);
    endtask

    task automatic wait_sb(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            step();
            t++;
        end
        if (sb.size() != 0) begin
            check(name, 1'b0, sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_alignwd"}, alignwd == 2'b00, int'(alignwd), 0);
        check({name, "_lane_ok"}, lane_ok == 2'b00, int'(lane_ok), 0);
        check({name, "_done"}, done == 1'b0, int'(done), 0);
        check({name, "_error"}, error == 1'b0, int'(error), 0);
    endtask

    // Monitor: alignwd shape/spacing and scoreboard compare on done rise
    initial begin : monitor
        exp_t e;
        last_rise[0] = -100;
        last_rise[1] = -100;
        forever begin
            @(negedge sclk);
            for (int n = 0; n < 2; n++) begin
                if (alignwd[n] && aw_q1[n]) check("alignwd_width", 1'b0, 2, 1);
                if (alignwd[n] && !aw_q1[n]) begin
                    check("alignwd_gap", (cyc - last_rise[n]) >= int'(SETTLE) + 2,
                          cyc - last_rise[n], int'(SETTLE) + 2);
                    last_rise[n] = cyc;
                    pulses[n]++;
                end
            end
            aw_q1 = alignwd;
            if (done && !done_q1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1'b0, 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_lane_ok", lane_ok == e.lane_ok, int'(lane_ok), int'(e.lane_ok));
                    check("sb_error", error == e.error, int'(error), int'(e.error));
                    check("sb_slip0", int'(slip_count[3:0]) == e.slip0, int'(slip_count[3:0]), e.slip0);
                    check("sb_slip1", int'(slip_count[7:4]) == e.slip1, int'(slip_count[7:4]), e.slip1);
                    check("sb_pulses0", pulses[0] == e.p0, pulses[0], e.p0);
                    check("sb_pulses1", pulses[1] == e.p1, pulses[1], e.p1);
                end
            end
            done_q1 = done;
        end
    end

    initial begin : stimulus
        int t;
        int p_hold;
        rst     = 1'b1;
        ready   = 1'b0;
        retrain = 1'b0;
        corrupt = 2'b00;
        set_lane(0, 8'h0F, 1'b0);
        set_lane(1, 8'h0F, 1'b0);
        repeat (3) step();
        check_all_zero("reset");
        check("reset_slip", slip_count == 8'h00, int'(slip_count), 0);
        rst = 1'b0;
        step();

        // Aligned lanes: lock at edge 11, done at edge 12
        push_exp(2'b11, 1'b0, 0, 0, 0, 0);
        ready = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            check("t1_lane_ok", lane_ok == ((e >= 11) ? 2'b11 : 2'b00), int'(lane_ok), (e >= 11) ? 3 : 0);
            check("t1_done", done == (e >= 12), int'(done), (e >= 12) ? 1 : 0);
            check("t1_alignwd", alignwd == 2'b00, int'(alignwd), 0);
        end
        check("t1_error", error == 1'b0, int'(error), 0);
        wait_sb("t1_timeout");

        // Lane0 three bits off
        set_lane(0, 8'hE1, 1'b0);
        set_lane(1, 8'h0F, 1'b0);
        push_exp(2'b11, 1'b0, 3, 0, 3, 0);
        pulse_retrain();
        wait_sb("t2_timeout");

        // Lane0 stuck on a non-pattern word: full budget then FAIL
        set_lane(0, 8'hAA, 1'b1);
        push_exp(2'b10, 1'b1, 8, 0, 8, 0);
        pulse_retrain();
        wait_sb("t3_timeout");

        // One corrupted word after 5 matches: slips a full rotation back to lock
        set_lane(0, 8'h0F, 1'b0);
        set_lane(1, 8'h0F, 1'b0);
        push_exp(2'b11, 1'b0, 8, 0, 8, 0);
        pulse_retrain();
        repeat (5) step();
        corrupt[0] = 1'b1;
        step();
        corrupt[0] = 1'b0;
        wait_sb("t4_timeout");

        // ready dropped while lane0 is settling
        set_lane(0, 8'hE1, 1'b0);
        pulse_retrain();
        t = 0;
        while (!alignwd[0] && t < 50) begin
            step();
            t++;
        end
        check("t5_first_slip", alignwd[0] == 1'b1, int'(alignwd[0]), 1);
        ready = 1'b0;
        repeat (3) step();
        check_all_zero("t5_drop");
        check("t5_slip_hold", slip_count == 8'h01, int'(slip_count), 1);
        p_hold = pulses[0];
        repeat (8) begin
            step();
            check("t5_idle_alignwd", alignwd == 2'b00, int'(alignwd), 0);
        end
        check("t5_no_pulses", pulses[0] == p_hold, pulses[0], p_hold);
        push_exp(2'b11, 1'b0, 2, 0, 2, 0);
        ready = 1'b1;
        repeat (3) step();
        check("t5_slip_cleared", slip_count == 8'h00, int'(slip_count), 0);
        wait_sb("t5_timeout");

        // retrain while locked: outputs clear same cycle, relock MATCH_CNT later
        push_exp(2'b11, 1'b0, 0, 0, 0, 0);
        pulse_retrain();
        check("t6_ok_clear", lane_ok == 2'b00, int'(lane_ok), 0);
        check("t6_done_clear", done == 1'b0, int'(done), 0);
        for (int e = 1; e <= 9; e++) begin
            step();
            check("t6_lane_ok", lane_ok == ((e >= 8) ? 2'b11 : 2'b00), int'(lane_ok), (e >= 8) ? 3 : 0);
            check("t6_done", done == (e >= 9), int'(done), (e >= 9) ? 1 : 0);
        end
        wait_sb("t6_timeout");

        // rst in the middle of lane0 training
        set_lane(0, 8'hAA, 1'b1);
        pulse_retrain();
        repeat (9) step();
        check("t6_pre_rst_slip", slip_count == 8'h02, int'(slip_count), 2);
        check("t6_pre_rst_ok", lane_ok == 2'b10, int'(lane_ok), 2);
        rst = 1'b1;
        step();
        check_all_zero("t6_rst");
        check("t6_rst_slip", slip_count == 8'h00, int'(slip_count), 0);
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
